// File: rtl/pe_logic_reduce.sv
// Reduction stage after the PE logical unit: folds each in_last-delimited vector of packed
// complex words into one word (signed real max/min, bitwise OR/AND) plus beat count and arg-index.
module pe_logic_reduce #(
   parameter int F_DATA = 32,
   parameter int H_DATA = F_DATA / 2,
   parameter int LEN_W  = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [F_DATA-1:0] in_data,
   input  logic              in_last,
   input  logic [1:0]        in_op,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [F_DATA-1:0] out_data,
   output logic [LEN_W-1:0]  out_count,
   output logic [LEN_W-1:0]  out_index,
   output logic              out_sat
);

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

   localparam logic [1:0]       OP_MAX  = 2'd0;
   localparam logic [1:0]       OP_MIN  = 2'd1;
   localparam logic [1:0]       OP_OR   = 2'd2;
   localparam logic [1:0]       OP_AND  = 2'd3;
   localparam logic [LEN_W-1:0] CNT_MAX = '1;

   state_t              state_q;
   logic [F_DATA-1:0]   acc_q, acc_d;
   logic [1:0]          op_q;
   logic [LEN_W-1:0]    count_q;
   logic [LEN_W-1:0]    beat_idx_q;
   logic [LEN_W-1:0]    best_idx_q, best_idx_d;
   logic                sat_q;

   logic                fire;
   logic                cnt_at_max;
   logic [LEN_W-1:0]    beat_idx_inc;
   logic signed [H_DATA-1:0] in_re, acc_re;

   assign in_ready     = (state_q != S_DONE);
   assign out_valid    = (state_q == S_DONE);
   assign fire         = in_valid & in_ready;
   assign cnt_at_max   = (count_q == CNT_MAX);
   assign beat_idx_inc = (beat_idx_q == CNT_MAX) ? CNT_MAX : beat_idx_q + LEN_W'(1);
   assign in_re        = in_data[F_DATA-1:H_DATA];
   assign acc_re       = acc_q[F_DATA-1:H_DATA];

   // Strict compare on the real half only, so ties keep the earlier beat.
   always_comb begin
      acc_d      = acc_q;
      best_idx_d = best_idx_q;
      unique case (op_q)
         OP_MAX: begin
            if (in_re > acc_re) begin
               acc_d      = in_data;
               best_idx_d = beat_idx_inc;
            end
         end
         OP_MIN: begin
            if (in_re < acc_re) begin
               acc_d      = in_data;
               best_idx_d = beat_idx_inc;
            end
         end
         OP_OR:   acc_d = acc_q | in_data;
         OP_AND:  acc_d = acc_q & in_data;
         default: acc_d = acc_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         acc_q      <= '0;
         op_q       <= OP_MAX;
         count_q    <= '0;
         beat_idx_q <= '0;
         best_idx_q <= '0;
         sat_q      <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (fire) begin
                  acc_q      <= in_data;
                  op_q       <= in_op;
                  count_q    <= LEN_W'(1);
                  beat_idx_q <= '0;
                  best_idx_q <= '0;
                  sat_q      <= 1'b0;
                  state_q    <= in_last ? S_DONE : S_ACC;
               end
            end
            S_ACC: begin
               if (fire) begin
                  acc_q      <= acc_d;
                  best_idx_q <= best_idx_d;
                  beat_idx_q <= beat_idx_inc;
                  if (cnt_at_max) begin
                     sat_q <= 1'b1;
                  end else begin
                     count_q <= count_q + LEN_W'(1);
                  end
                  state_q <= in_last ? S_DONE : S_ACC;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  acc_q      <= '0;
                  count_q    <= '0;
                  best_idx_q <= '0;
                  sat_q      <= 1'b0;
                  state_q    <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign out_data  = acc_q;
   assign out_count = count_q;
   assign out_index = best_idx_q;
   assign out_sat   = sat_q;

endmodule

// File: tb/tb_pe_logic_reduce.sv
// Directed bench for pe_logic_reduce: default-width instance plus a LEN_W=4 instance
// for the saturation cases.
module tb_pe_logic_reduce;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset;
   logic        in_valid, in_ready, in_last, out_valid, out_ready, out_sat;
   logic [31:0] in_data, out_data;
   logic [1:0]  in_op;
   logic [7:0]  out_count, out_index;

   logic        in_valid4, in_ready4, in_last4, out_valid4, out_ready4, out_sat4;
   logic [31:0] in_data4, out_data4;
   logic [1:0]  in_op4;
   logic [3:0]  out_count4, out_index4;

   pe_logic_reduce dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .in_op(in_op),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_count(out_count), .out_index(out_index), .out_sat(out_sat)
   );

   pe_logic_reduce #(.LEN_W(4)) dut4 (
      .clock(clock), .reset(reset),
      .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
      .in_last(in_last4), .in_op(in_op4),
      .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
      .out_count(out_count4), .out_index(out_index4), .out_sat(out_sat4)
   );

   int          checks = 0;
   int          errors = 0;
   logic [31:0] vec [0:31];
   int          vec_len;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Drives vec[0..vec_len-1] back-to-back; toggle_op changes in_op after the first beat.
   task automatic send_vec(input logic [1:0] op, input bit toggle_op, input bit close);
      for (int i = 0; i < vec_len; i++) begin
         chk("in_ready_beat", 32'(in_ready), 32'd1);
         in_valid = 1'b1;
         in_data  = vec[i];
         in_last  = close && (i == vec_len - 1);
         in_op    = (toggle_op && i > 0) ? 2'd2 : op;
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic expect_result(input string tag, input logic [31:0] data,
                                input logic [7:0] cnt, input logic [7:0] idx, input logic sat);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_data"},  out_data, data);
      chk({tag, "_count"}, 32'(out_count), 32'(cnt));
      chk({tag, "_index"}, 32'(out_index), 32'(idx));
      chk({tag, "_sat"},   32'(out_sat), 32'(sat));
      $display("vec %s data=%h count=%0d index=%0d sat=%0d", tag, out_data, out_count, out_index, out_sat);
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_op = 2'd0; out_ready = 1'b0;
      in_valid4 = 1'b0; in_data4 = '0; in_last4 = 1'b0; in_op4 = 2'd0; out_ready4 = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_count", 32'(out_count), 32'd0);
      chk("rst_out_index", 32'(out_index), 32'd0);
      chk("rst_out_sat", 32'(out_sat), 32'd0);

      // Single beat with out_ready held high: one-cycle result, then back to IDLE.
      out_ready = 1'b1;
      vec[0] = 32'h8001_1234; vec_len = 1;
      send_vec(2'd0, 1'b0, 1'b1);
      expect_result("single", 32'h8001_1234, 8'd1, 8'd0, 1'b0);
      tick();
      out_ready = 1'b0;
      chk("single_idle_valid", 32'(out_valid), 32'd0);
      chk("single_idle_ready", 32'(in_ready), 32'd1);

      // Reals {5,-3,7,7,-32768}, imag = beat number.
      vec[0] = 32'h0005_0000; vec[1] = 32'hFFFD_0001; vec[2] = 32'h0007_0002;
      vec[3] = 32'h0007_0003; vec[4] = 32'h8000_0004; vec_len = 5;
      send_vec(2'd0, 1'b0, 1'b1);
      expect_result("max", 32'h0007_0002, 8'd5, 8'd2, 1'b0);
      handshake("max");

      send_vec(2'd1, 1'b1, 1'b1);
      expect_result("min", 32'h8000_0004, 8'd5, 8'd4, 1'b0);
      handshake("min");

      vec[0] = 32'h0000_00F0; vec[1] = 32'h0F00_0000; vec[2] = 32'h0000_0001; vec_len = 3;
      send_vec(2'd2, 1'b0, 1'b1);
      expect_result("or", 32'h0F00_00F1, 8'd3, 8'd0, 1'b0);
      handshake("or");

      vec[0] = 32'hFFFF_0F0F; vec[1] = 32'hF0F0_FFFF; vec_len = 2;
      send_vec(2'd3, 1'b0, 1'b1);
      expect_result("and", 32'hF0F0_0F0F, 8'd2, 8'd0, 1'b0);
      handshake("and");

      // Backpressure: a beat offered during DONE must be ignored.
      vec[0] = 32'h0001_0000; vec[1] = 32'h0002_0001; vec_len = 2;
      send_vec(2'd0, 1'b0, 1'b1);
      expect_result("bp", 32'h0002_0001, 8'd2, 8'd1, 1'b0);
      in_valid = 1'b1; in_data = 32'hFFFF_FFFF; in_last = 1'b1; in_op = 2'd1;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_data", out_data, 32'h0002_0001);
         chk("bp_count", 32'(out_count), 32'd2);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp_hs_valid", 32'(out_valid), 32'd0);
      chk("bp_hs_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_data = 32'h1234_5678; in_last = 1'b1; in_op = 2'd0;
      tick();
      in_valid = 1'b0; in_last = 1'b0;
      expect_result("bp_next", 32'h1234_5678, 8'd1, 8'd0, 1'b0);
      handshake("bp_next");

      // Reset in the middle of a vector discards it.
      vec[0] = 32'h0000_0001; vec[1] = 32'h0000_0002; vec[2] = 32'h0000_0004; vec_len = 3;
      send_vec(2'd2, 1'b0, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mrst_in_ready", 32'(in_ready), 32'd1);
      chk("mrst_valid", 32'(out_valid), 32'd0);
      chk("mrst_data", out_data, 32'd0);
      chk("mrst_count", 32'(out_count), 32'd0);
      chk("mrst_index", 32'(out_index), 32'd0);
      chk("mrst_sat", 32'(out_sat), 32'd0);
      vec[0] = 32'h0003_0000; vec[1] = 32'h0001_0001; vec_len = 2;
      send_vec(2'd1, 1'b0, 1'b1);
      expect_result("after_rst", 32'h0001_0001, 8'd2, 8'd1, 1'b0);
      handshake("after_rst");

      // LEN_W=4: 18-beat OR saturates count at 15.
      for (int i = 0; i < 18; i++) begin
         logic [31:0] one;
         one = 32'd1;
         in_valid4 = 1'b1; in_data4 = one << i; in_last4 = (i == 17); in_op4 = 2'd2;
         tick();
      end
      in_valid4 = 1'b0; in_last4 = 1'b0;
      chk("sat_or_valid", 32'(out_valid4), 32'd1);
      chk("sat_or_data", out_data4, 32'h0003_FFFF);
      chk("sat_or_count", 32'(out_count4), 32'd15);
      chk("sat_or_index", 32'(out_index4), 32'd0);
      chk("sat_or_sat", 32'(out_sat4), 32'd1);
      $display("vec sat_or data=%h count=%0d index=%0d sat=%0d", out_data4, out_count4, out_index4, out_sat4);
      out_ready4 = 1'b1;
      tick();
      out_ready4 = 1'b0;
      chk("sat_or_idle_valid", 32'(out_valid4), 32'd0);

      // LEN_W=4: 17-beat rising MAX, winning index pinned at 15.
      for (int i = 0; i < 17; i++) begin
         in_valid4 = 1'b1; in_data4 = {16'(i), 16'(i)}; in_last4 = (i == 16); in_op4 = 2'd0;
         tick();
      end
      in_valid4 = 1'b0; in_last4 = 1'b0;
      chk("sat_max_valid", 32'(out_valid4), 32'd1);
      chk("sat_max_data", out_data4, 32'h0010_0010);
      chk("sat_max_count", 32'(out_count4), 32'd15);
      chk("sat_max_index", 32'(out_index4), 32'd15);
      chk("sat_max_sat", 32'(out_sat4), 32'd1);
      $display("vec sat_max data=%h count=%0d index=%0d sat=%0d", out_data4, out_count4, out_index4, out_sat4);
      out_ready4 = 1'b1;
      tick();
      out_ready4 = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
